// File: rtl/otter_io_pkg.sv
// Shared OTTER IOBUS peripheral definitions: UART FSM states,
// STATUS bit positions and register offsets.
package otter_io_pkg;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_t;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;

    localparam logic [31:0] UART_DATA_OFS = 32'h0;
    localparam logic [31:0] UART_STAT_OFS = 32'h4;

endpackage

// File: rtl/otter_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is
// accepted only when a pop happens in the same cycle.
module otter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];
    assign wr_ok = push && (!full || pop);
    assign rd_ok = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/otter_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
// Define OTTER_UART_PARITY_EN to add an even-parity bit (8E1).
module otter_uart_tx
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          DEPTH        = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d;

    logic          sel_data, sel_stat;
    logic          push, pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          baud_done;
    logic          unused_bus;

    assign sel_data   = (IOBUS_ADDR == BASE_ADDR + UART_DATA_OFS);
    assign sel_stat   = (IOBUS_ADDR == BASE_ADDR + UART_STAT_OFS);
    assign push       = IOBUS_WR && sel_data;
    assign baud_done  = (baud_q == '0);
    assign unused_bus = ^IOBUS_OUT[31:8];

    otter_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   (IOBUS_OUT[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A set caused by a dropped push beats a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (IOBUS_WR && sel_stat && IOBUS_OUT[ST_OVF_BIT]) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_comb begin
        IOBUS_IN = '0;
        if (sel_stat) begin
            IOBUS_IN[ST_BUSY_BIT]         = (state_q != UART_IDLE) || !fifo_empty;
            IOBUS_IN[ST_FULL_BIT]         = fifo_full;
            IOBUS_IN[ST_EMPTY_BIT]        = fifo_empty;
            IOBUS_IN[ST_OVF_BIT]          = ovf_q;
            IOBUS_IN[ST_CNT_LSB +: CW]    = fifo_count;
        end
    end

    // Data bits rotate rather than shift, so the byte is intact for parity.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        TX      = 1'b1;
        unique case (state_q)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = BAUD_MAX;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                TX = 1'b0;
                if (baud_done) begin
                    baud_d  = BAUD_MAX;
                    bit_d   = 3'd0;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            UART_DATA: begin
                TX = shift_q[0];
                if (baud_done) begin
                    baud_d  = BAUD_MAX;
                    shift_d = {shift_q[0], shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef OTTER_UART_PARITY_EN
                        state_d = UART_PARITY;
`else
                        state_d = UART_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef OTTER_UART_PARITY_EN
            UART_PARITY: begin
                TX = ^shift_q;
                if (baud_done) begin
                    baud_d  = BAUD_MAX;
                    state_d = UART_STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            UART_STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        baud_d  = BAUD_MAX;
                        state_d = UART_START;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
